// File: rtl/mux_arb_rr_if.sv
// Merge-point bundle: two FWFT FIFO heads in, one merged push stream plus counters out.
interface mux_arb_rr_if #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 8
);
  logic [DATA_SIZE-1:0] data_f0;
  logic [DATA_SIZE-1:0] data_f1;
  logic                 empty_f0;
  logic                 empty_f1;
  logic                 almost_full_out;
  logic                 pop_f0;
  logic                 pop_f1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 push_out;
  logic [CNT_SIZE-1:0]  count_f0;
  logic [CNT_SIZE-1:0]  count_f1;
  logic                 idle;

  // Arbiter side.
  modport slave (
    input  data_f0, data_f1, empty_f0, empty_f1, almost_full_out,
    output pop_f0, pop_f1, data_out, push_out, count_f0, count_f1, idle
  );

  // FIFO / downstream side.
  modport master (
    output data_f0, data_f1, empty_f0, empty_f1, almost_full_out,
    input  pop_f0, pop_f1, data_out, push_out, count_f0, count_f1, idle
  );
endinterface

// File: rtl/mux_arb_rr.sv
// Two-source round-robin merge of FWFT FIFOs into one downstream push stream.
// Latency: pop is combinational in grant cycle N; data_out/push_out registered in N+1.
// Backpressure: almost_full_out=1 blocks new grants; the one push already in flight still lands.
module mux_arb_rr #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 8
) (
  input  logic       clk,
  input  logic       reset_L,
  mux_arb_rr_if.slave bus
);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } state_t;

  state_t state;
  logic   grant0;
  logic   grant1;
  logic   any_grant;

  // A lone non-empty source always wins; a tie goes to the source not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_L && !bus.almost_full_out) begin
      if (!bus.empty_f0 && (bus.empty_f1 || state == LAST1)) begin
        grant0 = 1'b1;
      end else if (!bus.empty_f1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign any_grant  = grant0 | grant1;
  assign bus.pop_f0 = grant0;
  assign bus.pop_f1 = grant1;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= LAST1;
      bus.data_out <= '0;
      bus.push_out <= 1'b0;
      bus.count_f0 <= '0;
      bus.count_f1 <= '0;
      bus.idle     <= 1'b1;
    end else begin
      bus.push_out <= any_grant;
      bus.idle     <= ~any_grant;
      if (grant0) begin
        state        <= LAST0;
        bus.data_out <= bus.data_f0;
        bus.count_f0 <= bus.count_f0 + CNT_SIZE'(1);
      end else if (grant1) begin
        state        <= LAST1;
        bus.data_out <= bus.data_f1;
        bus.count_f1 <= bus.count_f1 + CNT_SIZE'(1);
      end
    end
  end

  a_one_pop : assert property (@(posedge clk) disable iff (!reset_L)
    !(bus.pop_f0 && bus.pop_f1));

  a_pop_legal : assert property (@(posedge clk) disable iff (!reset_L)
    !((bus.pop_f0 && bus.empty_f0) || (bus.pop_f1 && bus.empty_f1) ||
      ((bus.pop_f0 || bus.pop_f1) && bus.almost_full_out)));

endmodule

// File: tb/tb_mux_arb_rr.sv
module tb_mux_arb_rr;
  localparam int DW = 6;
  localparam int CW = 8;

  logic clk;
  logic reset_L;
  int   pass_cnt;
  int   chk_cnt;

  mux_arb_rr_if #(.DATA_SIZE(DW), .CNT_SIZE(CW)) bus ();

  mux_arb_rr #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two edges, release between edges, settle.
  task automatic do_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic e0, input logic e1, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic af);
    bus.empty_f0        = e0;
    bus.empty_f1        = e1;
    bus.data_f0         = d0;
    bus.data_f1         = d1;
    bus.almost_full_out = af;
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b0);
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b00) $display("FAIL reset_pops got=%b exp=00", {bus.pop_f0, bus.pop_f1});
    else pass_cnt++;
    chk_cnt++;
    if (bus.data_out !== 6'h00 || bus.push_out !== 1'b0 || bus.idle !== 1'b1)
      $display("FAIL reset_out got data=%h push=%b idle=%b exp data=00 push=0 idle=1", bus.data_out, bus.push_out, bus.idle);
    else pass_cnt++;
    chk_cnt++;
    if (bus.count_f0 !== 8'h00 || bus.count_f1 !== 8'h00)
      $display("FAIL reset_counts got=%h/%h exp=00/00", bus.count_f0, bus.count_f1);
    else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic [1:0]    exp_pop[4];
    logic [DW-1:0] exp_dat[4];
    exp_pop = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_dat = '{6'h05, 6'h25, 6'h05, 6'h25};
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if ({bus.pop_f0, bus.pop_f1} !== exp_pop[i])
        $display("FAIL alt_pop[%0d] got=%b exp=%b", i, {bus.pop_f0, bus.pop_f1}, exp_pop[i]);
      else pass_cnt++;
      next_cycle();
      chk_cnt++;
      if (bus.data_out !== exp_dat[i] || bus.push_out !== 1'b1 || bus.idle !== 1'b0)
        $display("FAIL alt_out[%0d] got data=%h push=%b idle=%b exp data=%h push=1 idle=0",
                 i, bus.data_out, bus.push_out, bus.idle, exp_dat[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (bus.count_f0 !== 8'd2 || bus.count_f1 !== 8'd2)
      $display("FAIL alt_counts got=%0d/%0d exp=2/2", bus.count_f0, bus.count_f1);
    else pass_cnt++;
  endtask

  task automatic test_only_f1();
    set_src(1'b1, 1'b0, 6'h05, 6'h11, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if ({bus.pop_f0, bus.pop_f1} !== 2'b01)
        $display("FAIL f1only_pop[%0d] got=%b exp=01", i, {bus.pop_f0, bus.pop_f1});
      else pass_cnt++;
      next_cycle();
    end
    chk_cnt++;
    if (bus.count_f1 !== 8'd3 || bus.count_f0 !== 8'd0 || bus.data_out !== 6'h11)
      $display("FAIL f1only_counts got f0=%0d f1=%0d data=%h exp f0=0 f1=3 data=11", bus.count_f0, bus.count_f1, bus.data_out);
    else pass_cnt++;
    set_src(1'b0, 1'b0, 6'h05, 6'h11, 1'b0);
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b10)
      $display("FAIL f1only_tie got=%b exp=10", {bus.pop_f0, bus.pop_f1});
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (bus.count_f0 !== 8'd1 || bus.count_f1 !== 8'd3 || bus.data_out !== 6'h05)
      $display("FAIL f1only_after got f0=%0d f1=%0d data=%h exp f0=1 f1=3 data=05", bus.count_f0, bus.count_f1, bus.data_out);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b0);
    do_reset();
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b10)
      $display("FAIL bp_first got=%b exp=10", {bus.pop_f0, bus.pop_f1});
    else pass_cnt++;
    next_cycle();
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b1);
    chk_cnt++;
    if (bus.push_out !== 1'b1 || bus.data_out !== 6'h05)
      $display("FAIL bp_trailing got push=%b data=%h exp push=1 data=05", bus.push_out, bus.data_out);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if ({bus.pop_f0, bus.pop_f1} !== 2'b00)
        $display("FAIL bp_pop[%0d] got=%b exp=00", i, {bus.pop_f0, bus.pop_f1});
      else pass_cnt++;
      next_cycle();
      chk_cnt++;
      if (bus.push_out !== 1'b0 || bus.idle !== 1'b1 || bus.count_f0 !== 8'd1 || bus.count_f1 !== 8'd0)
        $display("FAIL bp_hold[%0d] got push=%b idle=%b cnt=%0d/%0d exp push=0 idle=1 cnt=1/0",
                 i, bus.push_out, bus.idle, bus.count_f0, bus.count_f1);
      else pass_cnt++;
    end
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b0);
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b01)
      $display("FAIL bp_resume got=%b exp=01", {bus.pop_f0, bus.pop_f1});
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (bus.push_out !== 1'b1 || bus.data_out !== 6'h25 || bus.count_f1 !== 8'd1)
      $display("FAIL bp_resume_out got push=%b data=%h cnt1=%0d exp push=1 data=25 cnt1=1", bus.push_out, bus.data_out, bus.count_f1);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    set_src(1'b1, 1'b0, 6'h0A, 6'h31, 1'b0);
    do_reset();
    next_cycle();
    set_src(1'b0, 1'b1, 6'h0A, 6'h31, 1'b0);
    repeat (255) next_cycle();
    chk_cnt++;
    if (bus.count_f0 !== 8'hFF || bus.count_f1 !== 8'h01)
      $display("FAIL wrap_pre got=%h/%h exp=ff/01", bus.count_f0, bus.count_f1);
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (bus.count_f0 !== 8'h00 || bus.count_f1 !== 8'h01 || bus.push_out !== 1'b1)
      $display("FAIL wrap_post got cnt=%h/%h push=%b exp cnt=00/01 push=1", bus.count_f0, bus.count_f1, bus.push_out);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    set_src(1'b0, 1'b0, 6'h05, 6'h25, 1'b0);
    do_reset();
    repeat (3) next_cycle();
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b01 || bus.count_f0 !== 8'd2 || bus.count_f1 !== 8'd1)
      $display("FAIL midrst_pre got pop=%b cnt=%0d/%0d exp pop=01 cnt=2/1", {bus.pop_f0, bus.pop_f1}, bus.count_f0, bus.count_f1);
    else pass_cnt++;
    #2;
    reset_L = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b00 || bus.push_out !== 1'b0 || bus.data_out !== 6'h00 ||
        bus.count_f0 !== 8'd0 || bus.count_f1 !== 8'd0 || bus.idle !== 1'b1)
      $display("FAIL midrst_clear got pop=%b push=%b data=%h cnt=%0d/%0d idle=%b exp 00/0/00/0/0/1",
               {bus.pop_f0, bus.pop_f1}, bus.push_out, bus.data_out, bus.count_f0, bus.count_f1, bus.idle);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.pop_f0, bus.pop_f1} !== 2'b10)
      $display("FAIL midrst_first got=%b exp=10", {bus.pop_f0, bus.pop_f1});
    else pass_cnt++;
    next_cycle();
    chk_cnt++;
    if (bus.data_out !== 6'h05 || bus.count_f0 !== 8'd1 || bus.count_f1 !== 8'd0)
      $display("FAIL midrst_after got data=%h cnt=%0d/%0d exp data=05 cnt=1/0", bus.data_out, bus.count_f0, bus.count_f1);
    else pass_cnt++;
  endtask

  task automatic test_empty();
    set_src(1'b0, 1'b1, 6'h2A, 6'h15, 1'b0);
    do_reset();
    next_cycle();
    set_src(1'b1, 1'b1, 6'h03, 6'h15, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if ({bus.pop_f0, bus.pop_f1} !== 2'b00)
        $display("FAIL empty_pop[%0d] got=%b exp=00", i, {bus.pop_f0, bus.pop_f1});
      else pass_cnt++;
      next_cycle();
      chk_cnt++;
      if (bus.push_out !== 1'b0 || bus.idle !== 1'b1 || bus.data_out !== 6'h2A || bus.count_f0 !== 8'd1)
        $display("FAIL empty_hold[%0d] got push=%b idle=%b data=%h cnt0=%0d exp push=0 idle=1 data=2a cnt0=1",
                 i, bus.push_out, bus.idle, bus.data_out, bus.count_f0);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset_L  = 1'b0;
    test_reset();
    test_alternate();
    test_only_f1();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_empty();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameter DATA_SIZE, default 6, sets the word width of both input streams and the output stream.
REQ-002 Parameter CNT_SIZE, default 8, sets the width of each per-source forwarded-word counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset_L  input  1  is an asynchronous, active-low reset.
REQ-005 Port data_f0  input  DATA_SIZE  is the head word of FIFO 0, valid while empty_f0=0 (first-word-fall-through).
REQ-006 Port data_f1  input  DATA_SIZE  is the head word of FIFO 1, valid while empty_f1=0.
REQ-007 Port empty_f0  input  1  is the FIFO 0 empty flag.
REQ-008 Port empty_f1  input  1  is the FIFO 1 empty flag.
REQ-009 Port almost_full_out  input  1  is downstream backpressure; 1 forbids new grants.
REQ-010 Port pop_f0  output  1  pops FIFO 0; combinational, asserted only in a grant-0 cycle.
REQ-011 Port pop_f1  output  1  pops FIFO 1; combinational, asserted only in a grant-1 cycle.
REQ-012 Port data_out  output  DATA_SIZE  is the registered merged word.
REQ-013 Port push_out  output  1  is the registered push to the downstream FIFO, qualifying data_out.
REQ-014 Port count_f0  output  CNT_SIZE  is the registered count of words forwarded from FIFO 0.
REQ-015 Port count_f1  output  CNT_SIZE  is the registered count of words forwarded from FIFO 1.
REQ-016 Port idle  output  1  is registered; 1 when the previous cycle made no grant.

Function
REQ-017 The arbiter SHALL be a two-state FSM, LAST0 and LAST1, recording the last granted source; there is no separate idle state.
REQ-018 A grant SHALL be made in cycle N only when almost_full_out=0 and at least one of empty_f0, empty_f1 is 0.
REQ-019 With exactly one source non-empty, that source SHALL be granted, independent of FSM state.
REQ-020 With both sources non-empty, the source not recorded by the FSM SHALL be granted: LAST1 grants f0, LAST0 grants f1.
REQ-021 On a grant to source k, the FSM SHALL move to LASTk at the next edge; with no grant, the FSM SHALL hold its state.
REQ-022 At most one of pop_f0, pop_f1 SHALL be 1 in any cycle.
REQ-023 A pop SHALL never be asserted while the corresponding empty flag is 1 or while almost_full_out=1.
REQ-024 On a grant in cycle N, data_out SHALL equal the granted data_fk and push_out SHALL be 1 in cycle N+1 (latency 1).
REQ-025 In a cycle after a no-grant cycle, push_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-026 countk SHALL increment by 1 in the cycle after each grant to source k and wrap modulo 2^CNT_SIZE (all-ones+1 -> 0).
REQ-027 idle SHALL be the registered inverse of "grant made this cycle".
REQ-028 If almost_full_out rises in cycle N, no pop SHALL occur in cycle N; a push_out from a cycle N-1 grant still appears in cycle N, and downstream reserves one slot for it.
REQ-029 Sustained traffic with both sources non-empty and no backpressure SHALL produce strict alternation f0,f1,f0,... at one word per cycle.

Reset
REQ-030 While reset_L=0, asynchronously: FSM=LAST1, data_out=0, push_out=0, count_f0=0, count_f1=0, idle=1.
REQ-031 While reset_L=0, pop_f0 and pop_f1 SHALL be 0 regardless of inputs.
REQ-032 Reset asserted mid-stream SHALL discard any in-flight grant; after release, the first tie SHALL go to f0.

Verification
REQ-033 Reset release; both non-empty; data_f0=0x05, data_f1=0x25; almost_full_out=0.
  - Pops: f0, f1, f0, f1 on consecutive cycles.
  - data_out: 0x05, 0x25, 0x05, 0x25, each one cycle after its pop.
REQ-034 Only f1 non-empty for 3 cycles, then both non-empty.
  - Pops: f1, f1, f1, then f0 (FSM is LAST1).
  - count_f1=3 before count_f0=1.
REQ-035 Both non-empty; almost_full_out=1 for 4 cycles.
  - No pops for the 4 cycles.
  - One trailing push_out, then idle=1 and counts frozen.
  - On release, grants resume with the non-last source.
REQ-036 Preload count_f0 to 0xFF via 255 f0-only grants, then one more f0 grant.
  - count_f0 reads 0x00 the following cycle; count_f1 is unchanged.
REQ-037 Assert reset_L=0 between clock edges during alternation.
  - Outputs clear immediately; pops drop to 0 in the same cycle.
  - After release with both non-empty, the first pop is f0.
REQ-038 Both empty for 5 cycles.
  - No pops; push_out=0; idle=1.
  - data_out holds its last value.
